serial_subtractor: RTL and testbench

- Bit-serial unsigned subtractor computing diff = a - b, LSB first, one bit per clock. It is the subtract counterpart of the team's adder cells.
- It reuses one full-subtractor cell iteratively to trade area for latency.
- It sits beside the adder blocks as the arithmetic "other direction" for datapaths where area matters more than speed.
- Operands load on a start pulse. The result is presented with a one-cycle done strobe.

---
 rtl/serial_subtractor_pkg.sv | 18 +
 rtl/serial_subtractor_full_subtractor.sv | 19 +
 rtl/serial_subtractor.sv | 114 +++++++++++
 tb/tb_serial_subtractor.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor.
//   state_e       : FSM state encoding (IDLE/SHIFT/DONE)
//   cnt_width()   : bit-counter width derived from the operand width
package serial_subtractor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // Counter only has to reach WIDTH-1, so $clog2(WIDTH) bits suffice.
    // WIDTH >= 2 keeps this at least 1.
    function automatic int cnt_width(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor cell: computes x - y - bin.
//   x    : minuend bit
//   y    : subtrahend bit
//   bin  : borrow in
//   d    : difference bit
//   bout : borrow out
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = x ^ y ^ bin;
    // Borrow when x=0,y=1, or when x==y and a borrow is pending.
    assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: diff = a - b, LSB first, one bit per clock,
// reusing a single full-subtractor cell.
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   start  : request, sampled only in IDLE
//   a, b   : minuend / subtrahend, captured on accepted start
//   busy   : high in SHIFT and DONE
//   done   : one-cycle pulse when diff/borrow hold a new result
//   diff   : a - b modulo 2^WIDTH
//   borrow : final borrow out, 1 iff a < b
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_e           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] res_d;
    logic             bin_q;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] diff_q;
    logic             borrow_q;

    logic fs_d;
    logic fs_bout;

    full_subtractor u_fs (
        .x    (a_q[0]),
        .y    (b_q[0]),
        .bin  (bin_q),
        .d    (fs_d),
        .bout (fs_bout)
    );

    // New difference bit enters at the MSB; after WIDTH shifts the first
    // (LSB) bit has reached position 0.
    assign res_d = {fs_d, res_q[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            bin_q    <= 1'b0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        bin_q   <= 1'b0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    a_q   <= a_q >> 1;
                    b_q   <= b_q >> 1;
                    res_q <= res_d;
                    bin_q <= fs_bout;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        diff_q   <= res_d;
                        borrow_q <= fs_bout;
                        done_q   <= 1'b1;
                        state_q  <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign diff   = diff_q;
    assign borrow = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Testbench for serial_subtractor: directed vector table on a WIDTH=8
// instance, hand-written multi-cycle sequences, and a full WIDTH=4 sweep.
module tb_serial_subtractor;

    logic       clk;
    logic       rst_n;

    logic       st8;
    logic [7:0] a8, b8;
    logic       busy8, done8, borrow8;
    logic [7:0] diff8;

    logic       st4;
    logic [3:0] a4, b4;
    logic       busy4, done4, borrow4;
    logic [3:0] diff4;

    int n_cmp;
    int n_fail;

    serial_subtractor #(.WIDTH(8)) u_dut8 (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (st8),
        .a      (a8),
        .b      (b8),
        .busy   (busy8),
        .done   (done8),
        .diff   (diff8),
        .borrow (borrow8)
    );

    serial_subtractor #(.WIDTH(4)) u_dut4 (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (st4),
        .a      (a4),
        .b      (b4),
        .busy   (busy4),
        .done   (done4),
        .diff   (diff4),
        .borrow (borrow4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] exp_diff;
        logic       exp_borrow;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    // Called at a negedge with the FSM in IDLE; returns at the negedge of the
    // first IDLE cycle after completion.
    task automatic op8(input logic [7:0] av, input logic [7:0] bv,
                       input logic [7:0] ed, input logic eb);
        logic [7:0] d0;
        int         lat;
        bit         chg;
        a8  = av;
        b8  = bv;
        st8 = 1'b1;
        @(negedge clk);
        st8 = 1'b0;
        chk("busy_at_start", busy8, 1);
        chk("done_at_start", done8, 0);
        d0  = diff8;
        lat = 0;
        chg = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (done8) begin
                lat = i;
                break;
            end
            if (diff8 !== d0) chg = 1;
        end
        chk("latency", lat, 8);
        chk("diff_hold_in_shift", 32'(chg), 0);
        chk("diff", diff8, ed);
        chk("borrow", borrow8, eb);
        chk("busy_in_done", busy8, 1);
        @(negedge clk);
        chk("done_one_cycle", done8, 0);
        chk("busy_back_idle", busy8, 0);
    endtask

    task automatic op4(input logic [3:0] av, input logic [3:0] bv);
        int lat;
        logic [3:0] ed;
        logic       eb;
        ed  = av - bv;
        eb  = (av < bv);
        a4  = av;
        b4  = bv;
        st4 = 1'b1;
        @(negedge clk);
        st4 = 1'b0;
        lat = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (done4) begin
                lat = i;
                break;
            end
        end
        if (lat != 4) chk("w4_latency", lat, 4);
        chk("w4_diff", diff4, ed);
        chk("w4_borrow", borrow4, eb);
        @(negedge clk);
    endtask

    initial begin
        int lat;
        int ndone;
        n_cmp  = 0;
        n_fail = 0;
        st8 = 1'b0; a8 = '0; b8 = '0;
        st4 = 1'b0; a4 = '0; b4 = '0;

        // Reset state
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_busy", busy8, 0);
        chk("rst_done", done8, 0);
        chk("rst_diff", diff8, 0);
        chk("rst_borrow", borrow8, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed vectors; last two run back to back
        vecs[0] = '{8'd200, 8'd55, 8'd145, 1'b0};
        vecs[1] = '{8'd5,   8'd10, 8'hFB,  1'b1};
        vecs[2] = '{8'd0,   8'd1,  8'hFF,  1'b1};
        vecs[3] = '{8'd0,   8'd0,  8'd0,   1'b0};
        vecs[4] = '{8'd9,   8'd3,  8'd6,   1'b0};
        vecs[5] = '{8'd3,   8'd9,  8'd250, 1'b1};
        for (int v = 0; v < 6; v++) begin
            op8(vecs[v].a, vecs[v].b, vecs[v].exp_diff, vecs[v].exp_borrow);
        end

        // Asynchronous reset during the 4th SHIFT cycle
        a8  = 8'd200;
        b8  = 8'd55;
        st8 = 1'b1;
        @(negedge clk);
        st8 = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy", busy8, 0);
        chk("abort_done", done8, 0);
        chk("abort_diff", diff8, 0);
        chk("abort_borrow", borrow8, 0);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done8) ndone++;
        end
        chk("abort_no_done", ndone, 0);
        op8(8'd255, 8'd255, 8'd0, 1'b0);

        // start held high; operands change mid-SHIFT
        a8  = 8'd100;
        b8  = 8'd1;
        st8 = 1'b1;
        @(negedge clk);
        chk("hold_busy", busy8, 1);
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (i == 3) begin
                a8 = 8'd7;
                b8 = 8'd7;
            end
            if (done8) begin
                lat = i;
                break;
            end
        end
        chk("hold_latency", lat, 8);
        chk("hold_diff", diff8, 99);
        chk("hold_borrow", borrow8, 0);
        @(negedge clk);
        chk("hold_idle_done", done8, 0);
        chk("hold_idle_busy", busy8, 0);
        @(negedge clk);
        chk("hold_restart_busy", busy8, 1);
        st8 = 1'b0;
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (done8) begin
                lat = i;
                break;
            end
        end
        chk("hold2_latency", lat, 8);
        chk("hold2_diff", diff8, 0);
        chk("hold2_borrow", borrow8, 0);
        @(negedge clk);
        chk("hold2_done_end", done8, 0);

        // Exhaustive WIDTH=4 sweep
        for (int x = 0; x < 16; x++) begin
            for (int y = 0; y < 16; y++) begin
                op4(4'(x), 4'(y));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
